// File: rtl/usr_sequencer.sv
// Command sequencer for the universal shift register: turns load/shift/rotate
// commands into cycle-by-cycle USR mode, serial-fill and parallel-load drives.
module usr_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       usr_mode,
  output logic             usr_sl,
  output logic             usr_sr,
  output logic [WIDTH-1:0] usr_pin,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ASR  = 3'd5;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   rem_q;
  logic               fill_q;
  logic               err_q;
  logic               cmd_ready_q;
  logic               busy_q;
  logic [1:0]         usr_mode_q;
  logic [WIDTH-1:0]   usr_pin_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_err_q;

  // Mode/pin registers are loaded with the value for the state being entered,
  // so they line up with the state and the USR acts in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      rem_q       <= '0;
      fill_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      usr_mode_q  <= MODE_HOLD;
      usr_pin_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q        <= cmd_op;
            rem_q       <= cmd_count;
            fill_q      <= cmd_fill;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_op == OP_LOAD) begin
              state_q    <= S_LOAD;
              usr_mode_q <= MODE_LOAD;
              usr_pin_q  <= cmd_data;
            end else if (cmd_op > OP_ASR) begin
              state_q <= S_DONE;
              err_q   <= 1'b1;
            end else if (cmd_count == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q    <= S_SHIFT;
              usr_mode_q <= (cmd_op == OP_SHL || cmd_op == OP_ROL) ? MODE_UP : MODE_DOWN;
            end
          end
        end
        S_LOAD: begin
          state_q    <= S_DONE;
          usr_mode_q <= MODE_HOLD;
          usr_pin_q  <= '0;
        end
        S_SHIFT: begin
          rem_q <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_q    <= S_DONE;
            usr_mode_q <= MODE_HOLD;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= usr_q;
          rsp_err_q   <= err_q;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Serial fill is taken live from usr_q: the USR output is registered, so it
  // already reflects every shift applied so far.
  always_comb begin
    usr_sl = 1'b0;
    usr_sr = 1'b0;
    if (state_q == S_SHIFT) begin
      case (op_q)
        OP_SHL:  usr_sr = fill_q;
        OP_SHR:  usr_sl = fill_q;
        OP_ROL:  usr_sr = usr_q[WIDTH-1];
        OP_ROR:  usr_sl = usr_q[0];
        OP_ASR:  usr_sl = usr_q[WIDTH-1];
        default: begin
          usr_sl = 1'b0;
          usr_sr = 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign usr_mode  = usr_mode_q;
  assign usr_pin   = usr_pin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
